sensor_bus_arbiter: RTL
=======================

# sensor_bus_arbiter

Round-robin arbiter that shares one sensor transaction engine (the block driven by `start_init`/`start_read` and answering `init_done`/`read_done`) among up to eight requesters. It grants the engine to one requester at a time and holds the selected start level until the engine reports done. A per-transaction watchdog ends a hung transaction, and the arbiter returns a one-cycle acknowledge with an error flag to the owner. It sits between the sensor sequencing controllers and the single sensor engine.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `IDW`, 2: owner index width, equal to clog2(N_REQ).
- `TIMEOUT`, 24'd1_000_000: maximum number of BUSY cycles without a matching done. Legal range is 1..2^24-1.

- `clk`  in  1  single clock; every flop is clocked on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req`  in  N_REQ  level request per requester. The requester holds it until it receives `ack`.
- `req_op`  in  N_REQ  operation per requester: 0 = init, 1 = read. It must be stable while `req` is high.
- `grant`  out  N_REQ  one-hot, registered, current owner.
- `owner`  out  IDW  index of the current owner. Valid while `busy` is high.
- `busy`  out  1  high from the first BUSY cycle through the ACK cycle.
- `ack`  out  N_REQ  one-cycle pulse to the owner on completion.
- `err`  out  1  qualifies `ack`: 1 = the watchdog timed out, 0 = the engine completed normally.
- `start_init`  out  1  level to the engine. High during BUSY when the latched op is 0.
- `start_read`  out  1  level to the engine. High during BUSY when the latched op is 1.
- `init_done`  in  1  engine completion for init.
- `read_done`  in  1  engine completion for read.

## Operation
- FSM has three states: IDLE, BUSY, ACK. All outputs are registered.
- Reset puts the FSM in IDLE and clears `grant`, `owner`, `busy`, `ack`, `err`, `start_init`, `start_read`, the timer and the pointer `ptr`. After reset, requester 0 has the highest priority.
- **IDLE:**
  - If `req` is nonzero, the winner is the first set bit searching upward from `ptr` with wrap-around.
  - The arbiter latches the winner's index and `req_op` bit, sets `grant` and the matching start level, clears the timer and moves to BUSY.
  - If `req` is zero, the FSM stays in IDLE.
- **BUSY:**
  - The start level is held and the timer increments every cycle.
  - A done is a match only if it corresponds to the latched op: `init_done` for op 0, `read_done` for op 1. Non-matching dones are ignored.
  - On a matching done, the FSM moves to ACK with `err`=0.
  - If the timer reaches TIMEOUT without a matching done, the FSM moves to ACK with `err`=1.
  - If the matching done arrives in the same cycle the timer reaches TIMEOUT, done wins and `err`=0.
- **ACK** (exactly one cycle):
  - `ack[owner]`=1, `err` is valid, and the start levels are 0.
  - `grant` and `busy` stay high for this cycle.
  - At exit, `ptr` = (owner+1) mod N_REQ and the FSM returns to IDLE with `grant`, `busy` and `err` cleared.
- If the owner drops `req` mid-transaction, there is no abort. The transaction runs to done or timeout and the `ack` is still issued.
- Requests that are not granted are only sampled in IDLE. Changes to `req` during BUSY and ACK have no effect.
- Round-robin pointer: the most recent winner gets the lowest priority in the next arbitration. Every continuously asserted request is granted within N_REQ transactions.
- Timer is 24 bits and saturates. Its value is don't-care outside BUSY.

## Timing
- Request to grant: `req` is sampled high in IDLE at edge E, and `grant`, `busy` and the start level go high after E. Latency is 1 cycle.
- Done to ack: a matching done sampled at edge D gives `ack` high for the cycle after D, and the start levels drop after D.
- Back-to-back: the next arbitration happens in the IDLE cycle after ACK. The minimum request-to-request spacing for one engine transaction is therefore 3 cycles plus the engine latency.
- Requester rule: drop `req` (or change `req_op`) no later than the edge at which `ack` is sampled. Otherwise the requester is re-arbitrated as a new request.
- Timeout: with no done, `ack` with `err`=1 appears TIMEOUT+1 cycles after `grant` rises.
- Asynchronous reset asserted in any state clears all outputs immediately, including a start level in flight. The engine must tolerate the start level being withdrawn.

## Test plan
- Single request: with N_REQ=4, TIMEOUT=16, assert `req`=4'b0010 with op=1, and the engine returns `read_done` 5 cycles after start. Required: `grant`=0010 one cycle later, `start_read` high for 5 cycles, then `ack`=0010 for one cycle with `err`=0, then back to IDLE.
- Round-robin fairness: hold `req`=4'b1111. Required grant order after reset is 0,1,2,3,0, and no requester gets two grants before all others have had one.
- Watchdog: grant requester 2 with op=0 and never assert done. Required: `ack`=0100 with `err`=1 exactly 17 cycles after `grant` rises, and `start_init` low during ACK.
- Done/timeout tie and mismatched done: assert `read_done` while op=0, then `init_done` on the cycle the timer reaches 16. Required: `read_done` is ignored, and the arbiter returns `ack` with `err`=0.
- Reset mid-BUSY: assert `rst` 3 cycles into a transaction. Required: all outputs are 0 immediately. After release with `req`=4'b1001, requester 0 wins.
- Requester withdrawal: drop `req[1]` mid-BUSY. Required: the transaction completes and `ack[1]` pulses once.

Source files
------------

// File: rtl/sensor_bus_arbiter_if.sv
// Bundle of request, grant and engine-handshake signals between the requesters,
// the arbiter and the single sensor transaction engine.
interface sensor_bus_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] req_op;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   owner;
    logic             busy;
    logic [N_REQ-1:0] ack;
    logic             err;
    logic             start_init;
    logic             start_read;
    logic             init_done;
    logic             read_done;

    // Arbiter side
    modport slave (
        input  req, req_op, init_done, read_done,
        output grant, owner, busy, ack, err, start_init, start_read
    );

    // Requester / engine side
    modport master (
        output req, req_op, init_done, read_done,
        input  grant, owner, busy, ack, err, start_init, start_read
    );
endinterface

// File: rtl/sensor_bus_arbiter.sv
// Round-robin arbiter sharing one sensor transaction engine among N_REQ requesters,
// with a per-transaction watchdog that forces an error acknowledge on a hung engine.
module sensor_bus_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned IDW     = 2,
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input logic                 clk,
    input logic                 rst,
    sensor_bus_arbiter_if.slave sbus
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StAck
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;
    logic             start_init_q, start_init_d;
    logic             start_read_q, start_read_d;
    logic             op_q, op_d;
    logic [23:0]      timer_q, timer_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             req_any;
    logic             win_found_hi;
    logic [IDW-1:0]   win_idx;
    logic             win_op;
    logic             done_match;

    // Round-robin winner: lowest set request at or above ptr, else lowest overall.
    always_comb begin
        win_found_hi = 1'b0;
        win_idx      = '0;
        req_any      = |sbus.req;
        for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
            if (((sbus.req & (N_REQ'(1) << j)) != '0) && (IDW'(j) >= ptr_q)) begin
                win_idx      = IDW'(j);
                win_found_hi = 1'b1;
            end
        end
        if (!win_found_hi) begin
            for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
                if ((sbus.req & (N_REQ'(1) << j)) != '0) begin
                    win_idx = IDW'(j);
                end
            end
        end
        win_op = sbus.req_op[win_idx];
    end

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        ack_d        = '0;
        err_d        = err_q;
        start_init_d = start_init_q;
        start_read_d = start_read_q;
        op_d         = op_q;
        timer_d      = timer_q;
        ptr_d        = ptr_q;
        // Only the done belonging to the latched operation counts.
        done_match   = op_q ? sbus.read_done : sbus.init_done;

        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    grant_d      = N_REQ'(1) << win_idx;
                    owner_d      = win_idx;
                    op_d         = win_op;
                    start_init_d = ~win_op;
                    start_read_d = win_op;
                    busy_d       = 1'b1;
                    err_d        = 1'b0;
                    timer_d      = '0;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                timer_d = (timer_q == 24'hFF_FFFF) ? timer_q : timer_q + 24'd1;
                // Done takes precedence over a watchdog expiry in the same cycle.
                if (done_match) begin
                    ack_d        = grant_q;
                    err_d        = 1'b0;
                    start_init_d = 1'b0;
                    start_read_d = 1'b0;
                    state_d      = StAck;
                end else if (timer_q >= TIMEOUT) begin
                    ack_d        = grant_q;
                    err_d        = 1'b1;
                    start_init_d = 1'b0;
                    start_read_d = 1'b0;
                    state_d      = StAck;
                end
            end
            StAck: begin
                grant_d = '0;
                busy_d  = 1'b0;
                err_d   = 1'b0;
                ptr_d   = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + IDW'(1);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            owner_q      <= '0;
            busy_q       <= 1'b0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            start_init_q <= 1'b0;
            start_read_q <= 1'b0;
            op_q         <= 1'b0;
            timer_q      <= '0;
            ptr_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            start_init_q <= start_init_d;
            start_read_q <= start_read_d;
            op_q         <= op_d;
            timer_q      <= timer_d;
            ptr_q        <= ptr_d;
        end
    end

    assign sbus.grant      = grant_q;
    assign sbus.owner      = owner_q;
    assign sbus.busy       = busy_q;
    assign sbus.ack        = ack_q;
    assign sbus.err        = err_q;
    assign sbus.start_init = start_init_q;
    assign sbus.start_read = start_read_q;

endmodule
